// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scan sequencer driving a 16:1 mux select and assembling a frame
module mux_scan_sequencer #(
  parameter int NCH   = 16,
  parameter int SELW  = 4,
  parameter int DWELL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cont,
  input  logic [NCH-1:0]  ch_mask,
  input  logic            y,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic [NCH-1:0]  frame,
  output logic            frame_valid,
  input  logic            frame_ready
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NCH-1:0]  frame_q, frame_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;

  logic            first_found, next_found, begin_scan;
  logic [SELW-1:0] first_idx, next_idx;

  // Lowest enabled channel of the incoming mask, and lowest enabled channel above sel (no wrap).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_idx   = SELW'(i);
      end
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_found = 1'b1;
        next_idx   = SELW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    frame_d    = frame_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    begin_scan = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin_scan = 1'b1;
      end
      S_SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          frame_d[sel_q] = y;
          if (next_found) begin
            sel_d = next_idx;
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (frame_ready) begin
          valid_d = 1'b0;
          if (cont) begin_scan = 1'b1;
          else      state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Continuous mode re-enters here on the handshake edge, so there is no idle gap.
    if (begin_scan) begin
      mask_d  = ch_mask;
      frame_d = '0;
      if (first_found) begin
        sel_d   = first_idx;
        cnt_d   = CNT_RELOAD;
        state_d = S_SCAN;
      end else begin
        state_d = S_DONE;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      frame_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign sel         = sel_q;
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Scan controller that drives the 4-bit select of the 16:1 single-bit mux and samples the mux output back into a 16-bit frame register. Each scan visits the enabled channels in ascending order and holds each select value for a programmable dwell time. The completed frame is presented on a valid/ready interface to downstream logic. Supports single-shot and continuous scanning.

Parameters:
NCH, 16, number of mux channels. Must equal 2**SELW.
SELW, 4, select width.
DWELL, 2, cycles each channel is held on sel, including the sample cycle. Must be at least 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a scan; sampled only in IDLE
cont  input  1  continuous mode; sampled at each frame handshake
ch_mask  input  NCH  channel enables, latched at scan start
y  input  1  mux output, i.e. the selected channel value
sel  output  SELW  mux select, registered
busy  output  1  high whenever state is not IDLE
frame  output  NCH  sampled channel values; bit k holds channel k
frame_valid  output  1  frame available
frame_ready  input  1  downstream accepts frame

Behaviour:
- One clock and one reset: clk, and rst_n, which is asynchronous and active-low. All registers use the async clear.
- Reset values: sel=0, frame=0, frame_valid=0, busy=0, internal mask=0, dwell counter=0, state=IDLE.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 at an edge:
  - Latch ch_mask and clear frame.
  - If the mask is nonzero: sel <= lowest set bit index, cnt <= DWELL-1, go to SCAN.
  - If the mask is zero: go directly to DONE with frame_valid <= 1 and frame=0.
- SCAN, every edge:
  - If cnt != 0: cnt <= cnt-1 and sel is held.
  - If cnt == 0: frame[sel] <= y, i.e. y is sampled in the last dwell cycle.
  - Then, if a higher enabled channel exists, sel <= the next set bit above sel (single-cycle priority search) and cnt <= DWELL-1.
  - Otherwise go to DONE and set frame_valid <= 1.
- Latency: frame_valid rises exactly popcount(mask)*DWELL edges after the start edge. Disabled channels read 0 in frame.
- DONE:
  - frame_valid and frame are held stable until frame_ready=1 at an edge (the handshake).
  - On handshake, frame_valid <= 0.
  - If cont=1 at that edge, relatch the current ch_mask and restart exactly as from IDLE with start, with no idle cycle.
  - If cont=0, go to IDLE.
- Outside the SCAN sample edge, sel holds its last value. It changes only in SCAN or at a scan start.
- start is ignored while busy. ch_mask changes are ignored mid-scan. frame_ready is ignored when frame_valid=0.
- Simultaneous frame_ready and start in DONE: start has no effect; only cont decides whether a new scan begins.
- Reset asserted mid-operation: all outputs clear immediately, with no wait for a clock edge. A partial frame is discarded.
- Wrap-around: the search never wraps. Channel 15 is always the last candidate in a scan.

Test Plan:
1. ch_mask=0xFFFF, DWELL=2, bench mux model y=pat[sel] with pat=0x1248, pulse start -> sel steps 0..15, each held 2 cycles; frame_valid rises 32 edges after start; frame=0x1248.
2. ch_mask=0x00F0, same pat -> sel visits only 4,5,6,7; frame_valid after 8 edges; frame=0x0040.
3. ch_mask=0x0000, pulse start -> frame_valid=1 one edge later, frame=0x0000, busy=1 until handshake.
4. frame_ready held low for 5 cycles after valid, start pulsed during the wait -> frame_valid, frame and sel stable; no new scan starts; busy falls one edge after frame_ready=1.
5. cont=1, pat changed to 0xFFFF during the first scan's DONE -> second scan begins on the handshake edge; second frame=0xFFFF; frame_valid low for exactly 32 cycles between frames.
6. rst_n pulsed low while sel=7 mid-scan -> sel, frame, frame_valid and busy go to 0 without a clock edge; after release, a fresh start yields a correct full frame of 0x1248.
